// File: rtl/oran_tod_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oran_tod_pkg : shared ToD types, constants and the ns-with-wrap helper
// Revision     : 1.0
// ----------------------------------------------------------------------------
package oran_tod_pkg;

  localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

  typedef struct packed {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] fns;
  } tod96_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ADJUST = 1'b1
  } adj_state_e;

  // Both operands are below one second, so at most a single wrap can occur.
  function automatic tod96_t tod_add_ns(input tod96_t t, input logic [31:0] add_ns);
    tod96_t      r;
    logic [32:0] sum;
    r   = t;
    sum = {1'b0, t.ns} + {1'b0, add_ns};
    if (sum >= {1'b0, NS_PER_SEC}) begin
      sum   = sum - {1'b0, NS_PER_SEC};
      r.sec = t.sec + 48'd1;
    end
    r.ns = sum[31:0];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oran_tod_ch_offset.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oran_tod_ch_offset : two-stage per-channel ns offset pipe (add+wrap, output)
// Revision           : 1.0
// ----------------------------------------------------------------------------
module oran_tod_ch_offset
  import oran_tod_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  tod96_t      core_tod,
  input  logic        core_locked,
  input  logic [31:0] offset_ns,
  output tod96_t      tod_out,
  output logic        tod_valid
);

  tod96_t s1_d;
  tod96_t s1_q;
  tod96_t s2_q;
  logic   v1_q;
  logic   v2_q;

  always_comb begin
    s1_d = tod_add_ns(core_tod, offset_ns);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      v1_q <= 1'b0;
      s2_q <= '0;
      v2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      v1_q <= core_locked;
      s2_q <= s1_q;
      v2_q <= v1_q;
    end
  end

  assign tod_out   = s2_q;
  assign tod_valid = v2_q;

endmodule
`default_nettype wire

// File: rtl/oran_tod_counter_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// oran_tod_counter_mc : multi-channel 96b ToD counter with adjust window and 1PPS
// Revision            : 1.0
// ----------------------------------------------------------------------------
module oran_tod_counter_mc
  import oran_tod_pkg::*;
#(
  parameter int          NUM_CH        = 2,
  parameter int          PPS_WIDTH_CYC = 10,
  parameter logic [31:0] DEF_PERIOD    = 32'h0004_0000
) (
  input  logic                  clk_tod,
  input  logic                  rst_tod_n,
  input  logic [95:0]           ptp_seconds_data,
  input  logic                  ptp_load_valid,
  input  logic [31:0]           cfg_period,
  input  logic                  adj_valid,
  input  logic [31:0]           adj_period,
  input  logic [15:0]           adj_count,
  input  logic [32*NUM_CH-1:0]  ch_offset,
  output logic [96*NUM_CH-1:0]  oran_tod_time_of_day_96b_data,
  output logic [NUM_CH-1:0]     oran_tod_time_of_day_96b_valid,
  output logic                  adj_busy,
  output logic                  load_err,
  output logic                  pps_out
);

  localparam int              PPS_CW     = $clog2(PPS_WIDTH_CYC + 1);
  localparam logic [PPS_CW-1:0] PPS_RELOAD = PPS_CW'(PPS_WIDTH_CYC);

  tod96_t            tod_core_q, tod_core_d;
  logic              tod_locked_q, tod_locked_d;
  adj_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       adj_period_q, adj_period_d;
  logic [31:0]       cfg_period_q;
  logic              load_err_q, load_err_d;
  logic              wrap_q, wrap_d;
  logic [PPS_CW-1:0] pps_cnt_q, pps_cnt_d;
  logic              pps_q, pps_d;

  tod96_t            load_val;
  logic              load_ok;
  logic [31:0]       period_sel;
  logic [16:0]       fns_sum;
  logic [31:0]       step_ns;
  tod96_t            tod_inc;

  always_comb begin
    load_val   = tod96_t'(ptp_seconds_data);
    load_ok    = ptp_load_valid && (load_val.ns < NS_PER_SEC);
    period_sel = (state_q == ST_ADJUST) ? adj_period_q : cfg_period_q;

    // Fractional carry folds into the ns step before the second-wrap check.
    fns_sum     = {1'b0, tod_core_q.fns} + {1'b0, period_sel[15:0]};
    step_ns     = {16'h0000, period_sel[31:16]} + {31'h0, fns_sum[16]};
    tod_inc     = tod_add_ns(tod_core_q, step_ns);
    tod_inc.fns = fns_sum[15:0];

    tod_core_d   = load_ok ? load_val : tod_inc;
    tod_locked_d = tod_locked_q | load_ok;
    load_err_d   = ptp_load_valid && !load_ok;
    wrap_d       = !load_ok && tod_locked_q && (tod_inc.sec != tod_core_q.sec);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adj_period_d = adj_period_q;
    if (load_ok) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
    end else if (adj_valid && (adj_count != 16'd0)) begin
      state_d      = ST_ADJUST;
      cnt_d        = adj_count;
      adj_period_d = adj_period;
    end else if (state_q == ST_ADJUST) begin
      if (cnt_q == 16'd1) begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_comb begin
    if (wrap_q) begin
      pps_cnt_d = PPS_RELOAD;
    end else if (pps_cnt_q != '0) begin
      pps_cnt_d = pps_cnt_q - 1'b1;
    end else begin
      pps_cnt_d = '0;
    end
    pps_d = (pps_cnt_d != '0);
  end

  always_ff @(posedge clk_tod or negedge rst_tod_n) begin
    if (!rst_tod_n) begin
      tod_core_q   <= '0;
      tod_locked_q <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      adj_period_q <= 32'd0;
      cfg_period_q <= DEF_PERIOD;
      load_err_q   <= 1'b0;
      wrap_q       <= 1'b0;
      pps_cnt_q    <= '0;
      pps_q        <= 1'b0;
    end else begin
      tod_core_q   <= tod_core_d;
      tod_locked_q <= tod_locked_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      adj_period_q <= adj_period_d;
      cfg_period_q <= cfg_period;
      load_err_q   <= load_err_d;
      wrap_q       <= wrap_d;
      pps_cnt_q    <= pps_cnt_d;
      pps_q        <= pps_d;
    end
  end

  assign adj_busy = (state_q == ST_ADJUST);
  assign load_err = load_err_q;
  assign pps_out  = pps_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tod96_t ch_tod;

    oran_tod_ch_offset u_ch_offset (
      .clk         (clk_tod),
      .rst_n       (rst_tod_n),
      .core_tod    (tod_core_q),
      .core_locked (tod_locked_q),
      .offset_ns   (ch_offset[32*i +: 32]),
      .tod_out     (ch_tod),
      .tod_valid   (oran_tod_time_of_day_96b_valid[i])
    );

    assign oran_tod_time_of_day_96b_data[96*i +: 96] = ch_tod;
  end

endmodule
`default_nettype wire

// File: doc/oran_tod_counter_mc.md
# oran_tod_counter_mc

Parametrised multi-channel 96-bit time-of-day counter for the ORAN ToD subsystem. Keeps a free-running {48b seconds, 32b ns, 16b fractional ns} counter in the `clk_tod` domain. The counter is loaded from the PTP seconds bus and advanced by a programmable period. It also supports a bounded frequency-adjust window, and drives `NUM_CH` offset-corrected ToD outputs plus a 1PPS strobe. It is the successor to the single-channel ToD path: it adds per-channel offsets, period adjust, load validation and PPS generation.

## Interface
Parameters:
- `NUM_CH`, 2, number of ToD output channels (1..8)
- `PPS_WIDTH_CYC`, 10, PPS high time in `clk_tod` cycles (≥1)
- `DEF_PERIOD`, 32'h0004_0000, reset period, {ns[31:16], fns[15:0]}

Ports:
- `clk_tod`  in  1  ToD clock; sole clock
- `rst_tod_n`  in  1  reset, asynchronous assert, active-low
- `ptp_seconds_data`  in  96  load value {sec[95:48], ns[47:16], fns[15:0]}
- `ptp_load_valid`  in  1  load strobe, single-cycle
- `cfg_period`  in  32  nominal increment per cycle {ns, fns}
- `adj_valid`  in  1  start an adjust window, single-cycle
- `adj_period`  in  32  increment used during the adjust window
- `adj_count`  in  16  adjust window length in cycles
- `ch_offset`  in  32*NUM_CH  per-channel ns offset, unsigned, < 1e9
- `oran_tod_time_of_day_96b_data`  out  96*NUM_CH  per-channel ToD
- `oran_tod_time_of_day_96b_valid`  out  NUM_CH  per-channel valid
- `adj_busy`  out  1  adjust window active
- `load_err`  out  1  one-cycle pulse when a load is rejected
- `pps_out`  out  1  1PPS strobe

## Operation
- Core register `tod_core` (96b) plus `tod_locked` flag; both cleared on reset.
- Increment: {ns,fns} + period → fns carry goes into ns. If ns ≥ 1e9: ns −= 1e9 and sec += 1. Seconds wrap modulo 2^48.
- Period selection: `adj_period` while state is ADJUST, otherwise `cfg_period`. `cfg_period` is sampled every cycle.
- FSM:
  - IDLE → ADJUST on `adj_valid` with `adj_count` ≠ 0; loads `cnt` = `adj_count`.
  - In ADJUST, `cnt` decrements each cycle; returns to IDLE after the cycle where `cnt` = 1. `adj_busy` = (state == ADJUST).
  - `adj_valid` while in ADJUST restarts the window with the new values.
  - `adj_valid` with `adj_count` = 0 is ignored.
- Load: if `ptp_load_valid` and ns field < 1e9, `tod_core` ← value, `tod_locked` ← 1, and the FSM is forced to IDLE (any adjust is aborted).
  - If the ns field ≥ 1e9, the load is ignored and `load_err` pulses.
  - Load wins over increment and over a simultaneous `adj_valid`.
- Channel stage 1: per-channel ns_sum = core ns + `ch_offset[i]`. If ns_sum ≥ 1e9: subtract 1e9 and add 1 to seconds. fns passes through unchanged.
- Channel stage 2: output register. `valid[i]` = `tod_locked` delayed through the same two stages.
- PPS: when the core seconds field increments through the ns wrap (not through a load), `pps_out` goes high for `PPS_WIDTH_CYC` cycles.
  - A new wrap during the pulse restarts the width counter.
  - PPS is suppressed until `tod_locked` = 1.

## Timing
- Reset values: all outputs 0; `tod_core` = 0; FSM = IDLE.
- Load sampled at edge k → `tod_core` = V after edge k. Outputs show V + offset after edge k+2, and V + offset + period after edge k+3.
- Core → output latency is fixed at 2 cycles for every channel.
- `load_err` is registered: high for the one cycle after edge k.
- `pps_out` rises 1 cycle after the core ns wrap.
- Reset mid-window clears the FSM, `tod_locked` and the output pipe immediately.

## Structure
- Package `oran_tod_pkg` holds:
  - `NS_PER_SEC` = 32'd1_000_000_000
  - `tod96_t` struct {sec 48, ns 32, fns 16}
  - adjust FSM state enum
  - function `tod_add_ns`, which handles the ns add with wrap
- Sub-module `oran_tod_ch_offset` implements the two-stage per-channel offset pipe; instantiate it `NUM_CH` times with a generate loop.

## Test plan
- Reset, no load → all valid = 0 and `pps_out` = 0 indefinitely. Load {sec=5, ns=0} with period 4 ns, offsets 0 → output = {5, 0, 0} after 2 cycles, then +4 ns per cycle.
- Load ns = 999_999_996, period 4 ns → the next core value is {6, 0}. `pps_out` is high for 10 cycles, starting 1 cycle after the wrap.
- `ch_offset[1]` = 999_999_999 with core {5, 2} → ch1 output = {6, 1}, while ch0 = {5, 2}.
- `adj_valid` with `adj_count` = 3 and `adj_period` = 5 ns (cfg 4) → core advances 5, 5, 5, then 4. `adj_busy` is high for exactly 3 cycles.
- Load with ns = 1_000_000_000 → core unchanged and `load_err` pulses once. A valid load during ADJUST → `adj_busy` drops the next cycle.
- Period 32'h0000_8000 (0.5 ns) → ns increments by 1 every second cycle.
